// File: rtl/rv_reg_file_sb.sv
// Integer register file with init sweep and per-register busy scoreboard.
// Define RV_REG_FILE_BYPASS_EN for same-cycle write-to-read forwarding.
module rv_reg_file_sb #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            reset,
    output logic            ready_o,
    input  logic [AW-1:0]   rs1_addr_i,
    input  logic [AW-1:0]   rs2_addr_i,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    output logic            rs1_busy_o,
    output logic            rs2_busy_o,
    input  logic            issue_en_i,
    input  logic [AW-1:0]   issue_addr_i,
    input  logic            wr_en_i,
    input  logic [AW-1:0]   rd_addr_i,
    input  logic [XLEN-1:0] wr_data_i
);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t                state, state_nxt;
    logic [AW-1:0]         sw_idx;
    logic [XLEN-1:0]       rf [NUM_REGS];
    logic [NUM_REGS-1:0]   busy, busy_nxt;
    logic                  run;
    logic                  wr_ok;
    logic                  iss_ok;
    logic [XLEN-1:0]       arr1, arr2;
    logic                  byp1, byp2;

    assign run    = (state == RUN);
    assign wr_ok  = wr_en_i && (rd_addr_i != '0);
    assign iss_ok = issue_en_i && (issue_addr_i != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= INIT;
            sw_idx <= '0;
        end else begin
            state  <= state_nxt;
            if (state == INIT)
                sw_idx <= sw_idx + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            INIT: if (sw_idx == AW'(NUM_REGS - 1)) state_nxt = RUN;
            RUN:  state_nxt = RUN;
            default: state_nxt = INIT;
        endcase
    end

    // Array has no reset; the sweep zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == INIT)
                rf[sw_idx] <= '0;
            else if (wr_ok)
                rf[rd_addr_i] <= wr_data_i;
        end
    end

    // Set is applied after clear so a same-address issue wins.
    always_comb begin
        busy_nxt = busy;
        if (wr_ok)
            busy_nxt[rd_addr_i] = 1'b0;
        if (iss_ok)
            busy_nxt[issue_addr_i] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset)
            busy <= '0;
        else if (run)
            busy <= busy_nxt;
    end

    assign ready_o = run;

    assign arr1 = (run && rs1_addr_i != '0) ? rf[rs1_addr_i] : '0;
    assign arr2 = (run && rs2_addr_i != '0) ? rf[rs2_addr_i] : '0;

`ifdef RV_REG_FILE_BYPASS_EN
    assign byp1 = run && wr_ok && (rd_addr_i == rs1_addr_i);
    assign byp2 = run && wr_ok && (rd_addr_i == rs2_addr_i);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    always_comb begin
        rs1_data_o = byp1 ? wr_data_i : arr1;
        rs2_data_o = byp2 ? wr_data_i : arr2;
        rs1_busy_o = run ? busy[rs1_addr_i] : 1'b0;
        rs2_busy_o = run ? busy[rs2_addr_i] : 1'b0;
        if (byp1 && !(issue_en_i && issue_addr_i == rs1_addr_i))
            rs1_busy_o = 1'b0;
        if (byp2 && !(issue_en_i && issue_addr_i == rs2_addr_i))
            rs2_busy_o = 1'b0;
    end

endmodule

// File: tb/tb_rv_reg_file_sb.sv
// Scoreboard bench for rv_reg_file_sb: sweep, reset, writes, busy tracking.
module tb_rv_reg_file_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready_o;
    logic [4:0]  rs1_addr_i, rs2_addr_i;
    logic [31:0] rs1_data_o, rs2_data_o;
    logic        rs1_busy_o, rs2_busy_o;
    logic        issue_en_i;
    logic [4:0]  issue_addr_i;
    logic        wr_en_i;
    logic [4:0]  rd_addr_i;
    logic [31:0] wr_data_i;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic        port;
        logic [31:0] data;
        logic        busy;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [31:0] act_d;
    logic        act_b;

    always #5 clk = ~clk;

    rv_reg_file_sb #(.XLEN(32), .NUM_REGS(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .ready_o      (ready_o),
        .rs1_addr_i   (rs1_addr_i),
        .rs2_addr_i   (rs2_addr_i),
        .rs1_data_o   (rs1_data_o),
        .rs2_data_o   (rs2_data_o),
        .rs1_busy_o   (rs1_busy_o),
        .rs2_busy_o   (rs2_busy_o),
        .issue_en_i   (issue_en_i),
        .issue_addr_i (issue_addr_i),
        .wr_en_i      (wr_en_i),
        .rd_addr_i    (rd_addr_i),
        .wr_data_i    (wr_data_i)
    );

    task automatic drive(input logic wr, input logic [4:0] rd,
                         input logic [31:0] wd, input logic iss,
                         input logic [4:0] ia, input logic [4:0] a1,
                         input logic [4:0] a2);
        @(posedge clk);
        #1;
        wr_en_i      = wr;
        rd_addr_i    = rd;
        wr_data_i    = wd;
        issue_en_i   = iss;
        issue_addr_i = ia;
        rs1_addr_i   = a1;
        rs2_addr_i   = a2;
    endtask

    task automatic push(input string n, input logic p,
                        input logic [31:0] d, input logic b);
        exp_t x;
        x.name = n;
        x.port = p;
        x.data = d;
        x.busy = b;
        exp_q.push_back(x);
    endtask

    task automatic test_reset;
        int cnt;
        reset = 1'b1;
        drive(1'b1, 5'd5, 32'hFFFF_FFFF, 1'b1, 5'd6, 5'd5, 5'd6);
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 0", ready_o);
        end
        n_checks++;
        if (rs1_data_o !== 32'h0 || rs2_busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: data %h busy %b expected 0 0",
                     rs1_data_o, rs2_busy_o);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready_o) break;
            cnt++;
            n_checks++;
            if (rs1_data_o !== 32'h0 || rs2_busy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL sweep_out: data %h busy %b expected 0 0",
                         rs1_data_o, rs2_busy_o);
            end
        end
        n_checks++;
        if (cnt != 32) begin
            n_fail++;
            $display("FAIL sweep_len: got %0d cycles expected 32", cnt);
        end
        wr_en_i    = 1'b0;
        issue_en_i = 1'b0;
        push("init_ignore_wr", 1'b0, 32'h0, 1'b0);
        push("init_ignore_iss", 1'b1, 32'h0, 1'b0);
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act_d = e.port ? rs2_data_o : rs1_data_o;
            act_b = e.port ? rs2_busy_o : rs1_busy_o;
            n_checks++;
            if (act_d !== e.data) begin
                n_fail++;
                $display("FAIL %s data: got %h expected %h", e.name, act_d, e.data);
            end
            n_checks++;
            if (act_b !== e.busy) begin
                n_fail++;
                $display("FAIL %s busy: got %b expected %b", e.name, act_b, e.busy);
            end
        end
    endtask

    task automatic test_write_read;
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd1, 5'd0);
        drive(1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 5'd5, 5'd0);
        push("wr_x5", 1'b0, 32'hDEAD_BEEF, 1'b0);
        push("wr_x0_same", 1'b1, 32'h0, 1'b0);
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act_d = e.port ? rs2_data_o : rs1_data_o;
            act_b = e.port ? rs2_busy_o : rs1_busy_o;
            n_checks++;
            if (act_d !== e.data) begin
                n_fail++;
                $display("FAIL %s data: got %h expected %h", e.name, act_d, e.data);
            end
            n_checks++;
            if (act_b !== e.busy) begin
                n_fail++;
                $display("FAIL %s busy: got %b expected %b", e.name, act_b, e.busy);
            end
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);
        push("wr_x0_next", 1'b1, 32'h0, 1'b0);
        push("x5_hold", 1'b0, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act_d = e.port ? rs2_data_o : rs1_data_o;
            act_b = e.port ? rs2_busy_o : rs1_busy_o;
            n_checks++;
            if (act_d !== e.data) begin
                n_fail++;
                $display("FAIL %s data: got %h expected %h", e.name, act_d, e.data);
            end
            n_checks++;
            if (act_b !== e.busy) begin
                n_fail++;
                $display("FAIL %s busy: got %b expected %b", e.name, act_b, e.busy);
            end
        end
    endtask

    task automatic test_scoreboard;
        logic [31:0] wd [4] = '{32'h0, 32'h0, 32'h55, 32'h0};
        logic        we [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic        ie [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] xd [4] = '{32'h0, 32'h0, 32'h0, 32'h55};
        logic        xb [4];
        xb[0] = 1'b0;
        xb[1] = 1'b1;
`ifdef RV_REG_FILE_BYPASS_EN
        xd[2] = 32'h55;
        xb[2] = 1'b0;
`else
        xb[2] = 1'b1;
`endif
        xb[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(we[i], 5'd7, wd[i], ie[i], 5'd7, 5'd7, 5'd0);
            push($sformatf("sb_x7_c%0d", i), 1'b0, xd[i], xb[i]);
            push($sformatf("sb_x0_c%0d", i), 1'b1, 32'h0, 1'b0);
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act_d = e.port ? rs2_data_o : rs1_data_o;
                act_b = e.port ? rs2_busy_o : rs1_busy_o;
                n_checks++;
                if (act_d !== e.data) begin
                    n_fail++;
                    $display("FAIL %s data: got %h expected %h", e.name, act_d, e.data);
                end
                n_checks++;
                if (act_b !== e.busy) begin
                    n_fail++;
                    $display("FAIL %s busy: got %b expected %b", e.name, act_b, e.busy);
                end
            end
        end
    endtask

    task automatic test_simultaneous;
        drive(1'b1, 5'd9, 32'hA5A5_A5A5, 1'b1, 5'd9, 5'd1, 5'd2);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd5);
        push("same_addr_x9", 1'b0, 32'hA5A5_A5A5, 1'b1);
        push("x5_other", 1'b1, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act_d = e.port ? rs2_data_o : rs1_data_o;
            act_b = e.port ? rs2_busy_o : rs1_busy_o;
            n_checks++;
            if (act_d !== e.data) begin
                n_fail++;
                $display("FAIL %s data: got %h expected %h", e.name, act_d, e.data);
            end
            n_checks++;
            if (act_b !== e.busy) begin
                n_fail++;
                $display("FAIL %s busy: got %b expected %b", e.name, act_b, e.busy);
            end
        end
        drive(1'b1, 5'd4, 32'h0000_0044, 1'b1, 5'd3, 5'd0, 5'd0);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0, 5'd0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4);
        push("diff_iss_x3", 1'b0, 32'h0, 1'b1);
        push("diff_wr_x4", 1'b1, 32'h44, 1'b0);
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act_d = e.port ? rs2_data_o : rs1_data_o;
            act_b = e.port ? rs2_busy_o : rs1_busy_o;
            n_checks++;
            if (act_d !== e.data) begin
                n_fail++;
                $display("FAIL %s data: got %h expected %h", e.name, act_d, e.data);
            end
            n_checks++;
            if (act_b !== e.busy) begin
                n_fail++;
                $display("FAIL %s busy: got %b expected %b", e.name, act_b, e.busy);
            end
        end
    endtask

    task automatic test_bypass;
        logic [31:0] same;
`ifdef RV_REG_FILE_BYPASS_EN
        same = 32'hCAFE_F00D;
`else
        same = 32'h0;
`endif
        drive(1'b1, 5'd12, 32'hCAFE_F00D, 1'b0, 5'd0, 5'd12, 5'd9);
        push("byp_same_cycle", 1'b0, same, 1'b0);
        push("byp_other_x9", 1'b1, 32'hA5A5_A5A5, 1'b1);
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act_d = e.port ? rs2_data_o : rs1_data_o;
            act_b = e.port ? rs2_busy_o : rs1_busy_o;
            n_checks++;
            if (act_d !== e.data) begin
                n_fail++;
                $display("FAIL %s data: got %h expected %h", e.name, act_d, e.data);
            end
            n_checks++;
            if (act_b !== e.busy) begin
                n_fail++;
                $display("FAIL %s busy: got %b expected %b", e.name, act_b, e.busy);
            end
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd12, 5'd0);
        push("byp_next_cycle", 1'b0, 32'hCAFE_F00D, 1'b0);
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act_d = e.port ? rs2_data_o : rs1_data_o;
            act_b = e.port ? rs2_busy_o : rs1_busy_o;
            n_checks++;
            if (act_d !== e.data) begin
                n_fail++;
                $display("FAIL %s data: got %h expected %h", e.name, act_d, e.data);
            end
            n_checks++;
            if (act_b !== e.busy) begin
                n_fail++;
                $display("FAIL %s busy: got %b expected %b", e.name, act_b, e.busy);
            end
        end
    endtask

    task automatic test_mid_reset;
        int cnt;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd9);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_ready: got %b expected 0", ready_o);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready_o) break;
            cnt++;
        end
        n_checks++;
        if (cnt != 32) begin
            n_fail++;
            $display("FAIL mid_reset_len: got %0d cycles expected 32", cnt);
        end
        push("swept_x5", 1'b0, 32'h0, 1'b0);
        push("cleared_x9", 1'b1, 32'h0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act_d = e.port ? rs2_data_o : rs1_data_o;
            act_b = e.port ? rs2_busy_o : rs1_busy_o;
            n_checks++;
            if (act_d !== e.data) begin
                n_fail++;
                $display("FAIL %s data: got %h expected %h", e.name, act_d, e.data);
            end
            n_checks++;
            if (act_b !== e.busy) begin
                n_fail++;
                $display("FAIL %s busy: got %b expected %b", e.name, act_b, e.busy);
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        wr_en_i      = 1'b0;
        rd_addr_i    = '0;
        wr_data_i    = '0;
        issue_en_i   = 1'b0;
        issue_addr_i = '0;
        rs1_addr_i   = '0;
        rs2_addr_i   = '0;
        test_reset();
        test_write_read();
        test_scoreboard();
        test_simultaneous();
        test_bypass();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
